// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN instruction sequencer: opcodes, FSM states
// and instruction field geometry.
package cnn_pkg;

    localparam int OPC_W    = 4;
    localparam int LOOP_R_W = 8;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OP_LOOP = 4'd14;
    localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cnn_instr_sequencer_if.sv
// Instruction-memory read port and execution-unit dispatch handshake of the
// sequencer; master is the sequencer, slave is the memory/unit side.
interface cnn_instr_sequencer_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int NUM_UNITS   = 4
);
    logic                   imem_en;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [NUM_UNITS-1:0]   unit_valid;
    logic [INSTR_WIDTH-5:0] unit_operand;
    logic [NUM_UNITS-1:0]   unit_ready;
    logic [NUM_UNITS-1:0]   unit_done;

    modport master (
        output imem_en, imem_addr, unit_valid, unit_operand,
        input  imem_rdata, unit_ready, unit_done
    );

    modport slave (
        input  imem_en, imem_addr, unit_valid, unit_operand,
        output imem_rdata, unit_ready, unit_done
    );
endinterface

// File: rtl/cnn_loop_ctrl.sv
// Single-level hardware loop: repeat counter, active flag and the PC that
// follows a LOOP instruction.
module cnn_loop_ctrl
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  loop_exec_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    input  logic [LOOP_R_W-1:0]   repeat_i,
    output logic [ADDR_WIDTH-1:0] next_pc_o
);
    logic [LOOP_R_W-1:0] loop_cnt_q, loop_cnt_d, cnt_eff;
    logic                loop_active_q, loop_active_d;

    always_comb begin
        // A fresh LOOP (nothing in flight) picks up its repeat count from the operand.
        cnt_eff       = (loop_cnt_q == '0 && !loop_active_q) ? repeat_i : loop_cnt_q;
        next_pc_o     = (cnt_eff != '0) ? target_i : pc_i + 1'b1;
        loop_cnt_d    = loop_cnt_q;
        loop_active_d = loop_active_q;
        if (clear_i) begin
            loop_cnt_d    = '0;
            loop_active_d = 1'b0;
        end else if (loop_exec_i) begin
            if (cnt_eff != '0) begin
                loop_cnt_d    = cnt_eff - 1'b1;
                loop_active_d = 1'b1;
            end else begin
                loop_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loop_cnt_q    <= '0;
            loop_active_q <= 1'b0;
        end else begin
            loop_cnt_q    <= loop_cnt_d;
            loop_active_q <= loop_active_d;
        end
    end

endmodule

// File: rtl/cnn_instr_sequencer.sv
// CNN accelerator instruction sequencer: fetches a program from instruction
// memory and dispatches unit instructions over a valid/ready/done handshake.
module cnn_instr_sequencer
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int NUM_UNITS   = 4
) (
    input  logic                   s_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  initial_instruction_address,
    input  logic [COUNT_WIDTH-1:0] number_instrs,
    cnn_instr_sequencer_if.master  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [COUNT_WIDTH-1:0] instr_count
);
    localparam int               OPD_W = INSTR_WIDTH - OPC_W;
    localparam logic [OPC_W-1:0] NU    = OPC_W'(NUM_UNITS);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d, loop_pc;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, num_q, num_d, cnt_inc;
    logic                   err_q, err_d;
    logic [OPC_W-1:0]       sel_q, sel_d, op;
    logic [OPD_W-1:0]       opd_q, opd_d, opd_in;
    logic [NUM_UNITS-1:0]   sel_oh;
    logic                   is_unit, start_ok, xfer, sel_done;

    assign op       = bus.imem_rdata[INSTR_WIDTH-1 -: OPC_W];
    assign opd_in   = bus.imem_rdata[OPD_W-1:0];
    assign is_unit  = (op != OP_NOP) && (op <= NU);
    assign start_ok = (state_q == ST_IDLE) && start;
    assign cnt_inc  = (cnt_q < num_q) ? cnt_q + 1'b1 : cnt_q;
    assign sel_oh   = NUM_UNITS'(1) << sel_q;
    assign xfer     = (state_q == ST_ISSUE) && |(sel_oh & bus.unit_ready);
    assign sel_done = |(sel_oh & bus.unit_done);

    cnn_loop_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_loop (
        .clk_i       (s_clk),
        .rst_i       (reset),
        .clear_i     (start_ok),
        .loop_exec_i ((state_q == ST_EXEC) && (op == OP_LOOP)),
        .pc_i        (pc_q),
        .target_i    (opd_in[ADDR_WIDTH-1:0]),
        .repeat_i    (opd_in[ADDR_WIDTH +: LOOP_R_W]),
        .next_pc_o   (loop_pc)
    );

    always_ff @(posedge s_clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        err_d   = err_q;
        sel_d   = sel_q;
        opd_d   = opd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = initial_instruction_address;
                    num_d   = number_instrs;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (number_instrs == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                cnt_d = cnt_inc;
                if (op == OP_HALT) begin
                    state_d = ST_DONE;
                end else if (op == OP_LOOP || op == OP_NOP) begin
                    pc_d    = (op == OP_LOOP) ? loop_pc : pc_q + 1'b1;
                    state_d = (cnt_inc == num_q) ? ST_DONE : ST_FETCH;
                end else if (is_unit) begin
                    sel_d   = op - 1'b1;
                    opd_d   = opd_in;
                    state_d = ST_ISSUE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    pc_d = pc_q + 1'b1;
                    // A unit that finishes in the accept cycle needs no WAIT_DONE visit.
                    if (sel_done) state_d = (cnt_q == num_q) ? ST_DONE : ST_FETCH;
                    else          state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (sel_done) state_d = (cnt_q == num_q) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (reset) begin
            pc_q  <= '0;
            cnt_q <= '0;
            num_q <= '0;
            err_q <= 1'b0;
            sel_q <= '0;
            opd_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            num_q <= num_d;
            err_q <= err_d;
            sel_q <= sel_d;
            opd_q <= opd_d;
        end
    end

    always_comb begin
        bus.imem_en      = (state_q == ST_FETCH);
        bus.imem_addr    = pc_q;
        bus.unit_valid   = (state_q == ST_ISSUE) ? sel_oh : '0;
        bus.unit_operand = opd_q;
        busy             = (state_q != ST_IDLE);
        done             = (state_q == ST_DONE);
        error            = err_q;
        pc               = pc_q;
        instr_count      = cnt_q;
    end

endmodule
